// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, playfield geometry and the
// cell-to-bit-offset helper for the flattened Tetris frame vector.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = 10'd800;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = 10'd525;

  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int CELL_PX = 20;
  localparam int FRAME_W = COLS * ROWS * 3;

  localparam logic [9:0] BOARD_X0  = 10'd220;
  localparam logic [9:0] BOARD_Y0  = 10'd40;
  localparam logic [9:0] BORDER_PX = 10'd4;
  localparam logic [9:0] BOARD_X1  = BOARD_X0 + 10'(COLS * CELL_PX);
  localparam logic [9:0] BOARD_Y1  = BOARD_Y0 + 10'(ROWS * CELL_PX);

  typedef logic [2:0] color_t;

  localparam color_t BORDER_COLOR = 3'b111;
  localparam color_t BLACK        = 3'b000;

  function automatic logic [9:0] cell_offset(input logic [4:0] x, input logic [4:0] y);
    return 10'((int'(y) * COLS + int'(x)) * 3);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA output bundle: pixel colour, syncs, display enable and raster position.
interface vga_if;
  import vga_pkg::*;

  color_t     vga_pixel;
  logic       hsync_out;
  logic       vsync_out;
  logic       in_display;
  logic [9:0] count_x;
  logic [9:0] count_y;

  modport master (output vga_pixel, hsync_out, vsync_out, in_display, count_x, count_y);
  modport slave  (input  vga_pixel, hsync_out, vsync_out, in_display, count_x, count_y);
endinterface

// File: rtl/vga_timing.sv
// Raster counters for 800x525 total timing with active-low hsync/vsync
// and the visible-area flag, all decoded straight from the counter flops.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  output logic [9:0] count_x,
  output logic [9:0] count_y,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       in_display
);

  logic [9:0] count_x_q, count_x_d;
  logic [9:0] count_y_q, count_y_d;

  always_comb begin
    count_x_d = count_x_q + 10'd1;
    count_y_d = count_y_q;
    if (count_x_q == H_TOTAL - 10'd1) begin
      count_x_d = '0;
      count_y_d = (count_y_q == V_TOTAL - 10'd1) ? '0 : count_y_q + 10'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_x_q <= '0;
      count_y_q <= '0;
    end else begin
      count_x_q <= count_x_d;
      count_y_q <= count_y_d;
    end
  end

  assign count_x    = count_x_q;
  assign count_y    = count_y_q;
  assign hsync_out  = !((count_x_q >= H_SYNC_START) && (count_x_q < H_SYNC_END));
  assign vsync_out  = !((count_y_q >= V_SYNC_START) && (count_y_q < V_SYNC_END));
  assign in_display = (count_x_q < H_VISIBLE) && (count_y_q < V_VISIBLE);

endmodule

// File: rtl/vga_control.sv
// VGA front end for the Tetris playfield: raster timing plus cell lookup,
// border and blanking, producing a 3-bit colour each pixel clock.
module vga_control
  import vga_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [FRAME_W-1:0] frame,
  vga_if.master              vga
);

  if (int'(H_TOTAL) != int'(H_VISIBLE) + int'(H_FRONT) + int'(H_SYNC) + int'(H_BACK)) begin : g_bad_h_total
    $error("vga_control: H_TOTAL inconsistent with line timing");
  end
  if (int'(V_TOTAL) != int'(V_VISIBLE) + int'(V_FRONT) + int'(V_SYNC) + int'(V_BACK)) begin : g_bad_v_total
    $error("vga_control: V_TOTAL inconsistent with frame timing");
  end
  if ((int'(BOARD_X0) < int'(BORDER_PX)) || (int'(BOARD_Y0) < int'(BORDER_PX))) begin : g_bad_origin
    $error("vga_control: border extends past the top-left of the screen");
  end
  if ((int'(BOARD_X0) + COLS * CELL_PX + int'(BORDER_PX) > int'(H_VISIBLE)) ||
      (int'(BOARD_Y0) + ROWS * CELL_PX + int'(BORDER_PX) > int'(V_VISIBLE))) begin : g_bad_extent
    $error("vga_control: playfield plus border exceeds the visible area");
  end

  logic [9:0] cnt_x, cnt_y;
  logic       hs, vs, de;

  vga_timing u_timing (
    .clock      (clock),
    .reset_n    (reset_n),
    .count_x    (cnt_x),
    .count_y    (cnt_y),
    .hsync_out  (hs),
    .vsync_out  (vs),
    .in_display (de)
  );

  localparam logic [4:0] PX_LAST = 5'(CELL_PX - 1);

  // Sub-counters are primed to zero one pixel/line before the playfield so
  // they already hold (pixel-in-cell, cell index) for the first board pixel.
  logic [4:0] px_x_q, px_x_d, cell_x_q, cell_x_d;
  logic [4:0] px_y_q, px_y_d, cell_y_q, cell_y_d;

  always_comb begin
    px_x_d   = px_x_q;
    cell_x_d = cell_x_q;
    px_y_d   = px_y_q;
    cell_y_d = cell_y_q;
    if (cnt_x == BOARD_X0 - 10'd1) begin
      px_x_d   = '0;
      cell_x_d = '0;
    end else if (px_x_q == PX_LAST) begin
      px_x_d   = '0;
      cell_x_d = cell_x_q + 5'd1;
    end else begin
      px_x_d   = px_x_q + 5'd1;
    end
    if (cnt_x == H_TOTAL - 10'd1) begin
      if (cnt_y == BOARD_Y0 - 10'd1) begin
        px_y_d   = '0;
        cell_y_d = '0;
      end else if (px_y_q == PX_LAST) begin
        px_y_d   = '0;
        cell_y_d = cell_y_q + 5'd1;
      end else begin
        px_y_d   = px_y_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      px_x_q   <= '0;
      cell_x_q <= '0;
      px_y_q   <= '0;
      cell_y_q <= '0;
    end else begin
      px_x_q   <= px_x_d;
      cell_x_q <= cell_x_d;
      px_y_q   <= px_y_d;
      cell_y_q <= cell_y_d;
    end
  end

  logic   in_board, in_frame;
  color_t pixel;

  always_comb begin
    in_board = (cnt_x >= BOARD_X0) && (cnt_x < BOARD_X1) &&
               (cnt_y >= BOARD_Y0) && (cnt_y < BOARD_Y1);
    in_frame = (cnt_x >= BOARD_X0 - BORDER_PX) && (cnt_x < BOARD_X1 + BORDER_PX) &&
               (cnt_y >= BOARD_Y0 - BORDER_PX) && (cnt_y < BOARD_Y1 + BORDER_PX);
    pixel = BLACK;
    if (de) begin
      if (in_board) begin
        pixel = frame[cell_offset(cell_x_q, cell_y_q) +: 3];
      end else if (in_frame) begin
        pixel = BORDER_COLOR;
      end
    end
  end

  assign vga.vga_pixel  = pixel;
  assign vga.hsync_out  = hs;
  assign vga.vsync_out  = vs;
  assign vga.in_display = de;
  assign vga.count_x    = cnt_x;
  assign vga.count_y    = cnt_y;

endmodule

// File: tb/tb_vga_control.sv
// Bench for vga_control: expected outputs come from a raster-position model
// (pixel index -> x,y with plain division) and randomized frame contents.
module tb_vga_control;

  localparam int LINE       = 800;
  localparam int FRAME_CLKS = 420000;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b1;
  logic [599:0] frame   = '0;

  vga_if bus ();

  vga_control dut (
    .clock   (clock),
    .reset_n (reset_n),
    .frame   (frame),
    .vga     (bus)
  );

  always #20 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] pix;
  } point_t;

  function automatic logic [26:0] model(input int p, input logic [599:0] f);
    int         x, y, idx;
    logic       hs, vs, de;
    logic [2:0] pix;
    x   = p % 800;
    y   = p / 800;
    hs  = !(x >= 656 && x <= 751);
    vs  = !(y >= 490 && y <= 491);
    de  = (x < 640) && (y < 480);
    pix = 3'b000;
    if (de) begin
      if (x >= 220 && x < 420 && y >= 40 && y < 440) begin
        idx = (((y - 40) / 20) * 10 + (x - 220) / 20) * 3;
        pix = f[idx +: 3];
      end else if (x >= 216 && x < 424 && y >= 36 && y < 444) begin
        pix = 3'b111;
      end
    end
    return {x[9:0], y[9:0], hs, vs, de, pix};
  endfunction

  function automatic logic [26:0] observed();
    return {bus.count_x, bus.count_y, bus.hsync_out, bus.vsync_out, bus.in_display, bus.vga_pixel};
  endfunction

  task automatic tick();
    @(negedge clock);
    pos = (pos + 1) % FRAME_CLKS;
  endtask

  // Fast-forward to column 0 of a line by jumping the column counter near
  // the end of each skipped line; the row counter still advances normally.
  task automatic skip_to(input int line);
    while (pos != line * LINE) begin
      if (pos % LINE < LINE - 10) begin
        force dut.u_timing.count_x_q = 10'd790;
        #1;
        release dut.u_timing.count_x_q;
        pos = (pos / LINE) * LINE + LINE - 10;
      end
      tick();
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 600; i++) frame[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    logic [26:0] exp_v;
    exp_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 3'b000};
    rand_frame();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL reset_hold: got %h expected %h", observed(), exp_v);
      end
      @(negedge clock);
    end
    reset_n = 1'b1;
    pos = 0;
    tick();
    checks++;
    if ({bus.count_x, bus.count_y, bus.hsync_out, bus.vsync_out} !== {10'd1, 10'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_release: got x=%0d y=%0d hs=%b vs=%b expected x=1 y=0 hs=1 vs=1",
               bus.count_x, bus.count_y, bus.hsync_out, bus.vsync_out);
    end
  endtask

  task automatic test_line_timing();
    int   hs_low = 0, de_hi = 0, last_fall = -1;
    logic prev_hs = 1'b1;
    logic [26:0] exp_v;
    while (pos < 3 * LINE) begin
      exp_v = model(pos, frame);
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL line_cycle@%0d: got %h expected %h", pos, observed(), exp_v);
      end
      if (prev_hs && !bus.hsync_out) begin
        if (last_fall >= 0) begin
          checks++;
          if (pos - last_fall != LINE) begin
            errors++;
            $display("FAIL hsync_period: got %0d expected %0d", pos - last_fall, LINE);
          end
        end
        last_fall = pos;
      end
      prev_hs = bus.hsync_out;
      if (pos >= LINE) begin
        hs_low += int'(!bus.hsync_out);
        de_hi  += int'(bus.in_display);
        if (pos % LINE == LINE - 1) begin
          checks += 2;
          if (hs_low != 96) begin
            errors++;
            $display("FAIL hsync_width: got %0d expected 96", hs_low);
          end
          if (de_hi != 640) begin
            errors++;
            $display("FAIL de_per_line: got %0d expected 640", de_hi);
          end
          hs_low = 0;
          de_hi  = 0;
        end
      end
      if ($urandom_range(0, 199) == 0) rand_frame();
      tick();
    end
  endtask

  task automatic test_cell_mapping();
    point_t      pts [14];
    int          segs [3][2];
    logic [26:0] exp_v;
    pts = '{'{220, 40, 3'b001}, '{239, 59, 3'b001}, '{240, 40, 3'b010}, '{419, 439, 3'b100},
            '{220, 60, 3'b000}, '{216, 40, 3'b111}, '{423, 439, 3'b111}, '{300, 36, 3'b111},
            '{300, 443, 3'b111}, '{215, 40, 3'b000}, '{424, 40, 3'b000}, '{300, 35, 3'b000},
            '{219, 40, 3'b111}, '{420, 40, 3'b111}};
    segs = '{'{35, 41}, '{59, 61}, '{438, 444}};
    frame = '0;
    frame[2:0]     = 3'b001;
    frame[5:3]     = 3'b010;
    frame[599:597] = 3'b100;
    for (int s = 0; s < 3; s++) begin
      skip_to(segs[s][0]);
      repeat ((segs[s][1] - segs[s][0] + 1) * LINE) begin
        exp_v = model(pos, frame);
        checks++;
        if (observed() !== exp_v) begin
          errors++;
          $display("FAIL cell_cycle@%0d: got %h expected %h", pos, observed(), exp_v);
        end
        for (int i = 0; i < 14; i++) begin
          if (pos == pts[i].y * LINE + pts[i].x) begin
            checks++;
            if (bus.vga_pixel !== pts[i].pix) begin
              errors++;
              $display("FAIL cell_point(%0d,%0d): got %b expected %b",
                       pts[i].x, pts[i].y, bus.vga_pixel, pts[i].pix);
            end
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_random_cells();
    int          y;
    logic [26:0] exp_v;
    rand_frame();
    for (int k = 0; k < 6; k++) begin
      y = 40 + k * 66 + int'($urandom_range(0, 59));
      skip_to(y);
      repeat (LINE) begin
        exp_v = model(pos, frame);
        checks++;
        if (observed() !== exp_v) begin
          errors++;
          $display("FAIL random_cell@%0d: got %h expected %h", pos, observed(), exp_v);
        end
        if ($urandom_range(0, 149) == 0) rand_frame();
        tick();
      end
    end
  endtask

  task automatic test_blanking();
    int          segs [3][2];
    int          vs_low = 0, de_line = 0, x, y;
    logic [26:0] exp_v;
    segs = '{'{479, 481}, '{489, 492}, '{524, 524}};
    frame = '1;
    for (int s = 0; s < 3; s++) begin
      skip_to(segs[s][0]);
      repeat ((segs[s][1] - segs[s][0] + 1) * LINE) begin
        x = pos % LINE;
        y = pos / LINE;
        exp_v = model(pos, frame);
        checks++;
        if (observed() !== exp_v) begin
          errors++;
          $display("FAIL blank_cycle@%0d: got %h expected %h", pos, observed(), exp_v);
        end
        if (x >= 640 || y >= 480) begin
          checks++;
          if (bus.vga_pixel !== 3'b000) begin
            errors++;
            $display("FAIL blank_pixel(%0d,%0d): got %b expected 000", x, y, bus.vga_pixel);
          end
        end
        vs_low  += int'(!bus.vsync_out);
        de_line += int'(bus.in_display);
        if (x == LINE - 1) begin
          checks++;
          if (de_line != ((y < 480) ? 640 : 0)) begin
            errors++;
            $display("FAIL de_line%0d: got %0d expected %0d", y, de_line, (y < 480) ? 640 : 0);
          end
          de_line = 0;
        end
        tick();
      end
    end
    checks++;
    if (vs_low != 1600) begin
      errors++;
      $display("FAIL vsync_width: got %0d expected 1600", vs_low);
    end
    checks++;
    if ({bus.count_x, bus.count_y} !== 20'd0) begin
      errors++;
      $display("FAIL frame_wrap: got x=%0d y=%0d expected x=0 y=0", bus.count_x, bus.count_y);
    end
  endtask

  task automatic test_reset_mid();
    logic [26:0] exp_v;
    rand_frame();
    skip_to(300);
    repeat (400) tick();
    checks++;
    if ({bus.count_x, bus.count_y} !== {10'd400, 10'd300}) begin
      errors++;
      $display("FAIL pre_reset_pos: got x=%0d y=%0d expected x=400 y=300", bus.count_x, bus.count_y);
    end
    #5 reset_n = 1'b0;
    #1;
    pos = 0;
    checks++;
    if ({bus.count_x, bus.count_y, bus.hsync_out, bus.vsync_out} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d hs=%b vs=%b expected x=0 y=0 hs=1 vs=1",
               bus.count_x, bus.count_y, bus.hsync_out, bus.vsync_out);
    end
    repeat (2) begin
      @(negedge clock);
      checks++;
      if ({bus.count_x, bus.count_y} !== 20'd0) begin
        errors++;
        $display("FAIL reset_held: got x=%0d y=%0d expected x=0 y=0", bus.count_x, bus.count_y);
      end
    end
    reset_n = 1'b1;
    repeat (900) begin
      tick();
      exp_v = model(pos, frame);
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL post_reset@%0d: got %h expected %h", pos, observed(), exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_cell_mapping();
    test_random_cells();
    test_blanking();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(150000 * 40);
    $display("FAIL timeout: simulation exceeded its cycle budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_control.md
Name: vga_control

Overview:
- Generates 640x480@60 Hz VGA timing, one pixel per `clock` cycle; `clock` is the 25.175 MHz pixel clock.
- Renders the 10x20 Tetris playfield from a flattened 3-bit-per-cell frame input as scaled coloured cells, with a border, on a black background.
- Sits between the frame double-buffer (framer) and the VGA pins. Its vsync also paces game logic (tetriminogeneration, framer).

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse lines
- V_BACK, 33, vertical back porch
- COLS, 10, playfield columns
- ROWS, 20, playfield rows
- CELL_PX, 20, cell edge in pixels
- BOARD_X0, 220, playfield left pixel column
- BOARD_Y0, 40, playfield top line
- BORDER_PX, 4, border thickness around playfield
- BORDER_COLOR, 3'b111, border colour

Ports:
- clock  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- frame  in  COLS*ROWS*3 (600)  cell (x,y) colour at bits [(y*COLS+x)*3 +: 3]; x=0 is left, y=0 is top
- vga_pixel  out  3  bit0 red, bit1 green, bit2 blue
- hsync_out  out  1  horizontal sync, active low
- vsync_out  out  1  vertical sync, active low
- in_display  out  1  high in the visible region
- count_x  out  10  current pixel column, 0..799
- count_y  out  10  current line, 0..524

Behaviour:
- Counters:
  - count_x increments every clock and wraps 799->0.
  - On that wrap, count_y increments and wraps 524->0.
  - Line is 800 clocks; frame is 420000 clocks.
- Reset:
  - reset_n low asynchronously forces count_x=0 and count_y=0.
  - Held there until release; counting resumes on the first clock edge after release.
  - Applies equally mid-line or mid-frame, with no partial-state carry-over.
- Output decode: all other outputs decode combinationally from the counter registers and `frame` (zero latency, same cycle as count_x/count_y).
- Sync windows:
  - hsync_out = 0 iff 656 <= count_x <= 751.
  - vsync_out = 0 iff 490 <= count_y <= 491.
- in_display = (count_x < 640) && (count_y < 480).
- Pixel colour, in priority order:
  - in_display=0 -> 3'b000.
  - Playfield region: BOARD_X0 <= count_x < BOARD_X0+COLS*CELL_PX (220..419) and BOARD_Y0 <= count_y < BOARD_Y0+ROWS*CELL_PX (40..439).
    - cx = (count_x-BOARD_X0)/CELL_PX and cy = (count_y-BOARD_Y0)/CELL_PX.
    - Output = frame cell (cx,cy).
  - Border: inside the rectangle expanded by BORDER_PX on every side (216..423 by 36..443) but not in the playfield -> BORDER_COLOR.
  - Otherwise -> 3'b000.
- Frame sampling: `frame` is sampled live. Tear-free updates are the upstream framer's responsibility, via swapping on vsync.
- Division: divide-by-20 must not use a divider. Use cell sub-counters (pixel-in-cell 0..19 plus cell index) that reset at region entry; results must equal the arithmetic definition above.
- Parameter legality: derived constants must satisfy the following, checked by elaboration-time assertion:
  - total line = H_VISIBLE+H_FRONT+H_SYNC+H_BACK;
  - total frame = V_VISIBLE+V_FRONT+V_SYNC+V_BACK;
  - BOARD_X0-BORDER_PX >= 0;
  - playfield plus border fits inside the visible area.

Decomposition:
- Shared package vga_pkg:
  - timing constants;
  - COLS, ROWS, CELL_PX;
  - a 3-bit colour typedef;
  - a cell-index function returning the bit offset (y*COLS+x)*3.
- Sub-module vga_timing: counters, sync, and in_display.
- Colour/cell mapping stays in vga_control.

Test Plan:
- Reset: assert reset_n=0 mid-frame at (400,300) -> count_x=0, count_y=0 immediately. After release, count_x=1 on the next edge; hsync_out=1, vsync_out=1.
- Line timing: free-run -> hsync_out low exactly for count_x 656..751 (96 clocks); period 800 clocks; count_y increments when count_x wraps 799->0.
- Frame timing: free-run -> vsync_out low for count_y 490..491 (1600 clocks); period 420000 clocks; in_display high exactly 640 clocks per line on lines 0..479.
- Cell mapping: frame cell (0,0)=3'b001, (1,0)=3'b010, (9,19)=3'b100, rest 0 ->
  - pixel 001 at (220,40) and (239,59);
  - 010 at (240,40);
  - 100 at (419,439);
  - 000 at (220,60).
- Border/background:
  - 111 at (216,40), (423,439), (300,36), (300,443);
  - 000 at (215,40), (424,40), (300,35), (0,0).
- Blanking: all frame cells 3'b111 -> vga_pixel=000 whenever count_x>=640 or count_y>=480, including during both sync pulses.
